// File: rtl/fios_mm_pkg.sv
// Shared types and sizing helpers for the word-serial FIOS Montgomery multiplier.
package fios_mm_pkg;

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_COMPUTE,
        ST_SUB,
        ST_OUT
    } state_e;

    localparam int DEF_WORD_WIDTH = 17;
    localparam int CARRY_W        = DEF_WORD_WIDTH + 2;

    // Width of a counter that must reach n inclusive (j runs 0..s).
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

    function automatic int carry_width(input int w);
        return w + 2;
    endfunction

endpackage

// File: rtl/fios_mm_step.sv
// Combinational FIOS inner step: t_j + a_j*b_i + m*p_j + carry_in, split into low word and carry.
module fios_mm_step
    import fios_mm_pkg::*;
#(
    parameter int WORD_WIDTH = DEF_WORD_WIDTH,
    parameter int CW         = CARRY_W
) (
    input  logic [WORD_WIDTH-1:0] t_j,
    input  logic [WORD_WIDTH-1:0] a_j,
    input  logic [WORD_WIDTH-1:0] b_i,
    input  logic [WORD_WIDTH-1:0] m,
    input  logic [WORD_WIDTH-1:0] p_j,
    input  logic [CW-1:0]         carry_in,
    output logic [WORD_WIDTH-1:0] sum_lo,
    output logic [CW-1:0]         carry_out
);

    localparam int SW = 2 * WORD_WIDTH + 2;

    logic [SW-1:0] sum;

    assign sum       = SW'(t_j) + SW'(a_j) * SW'(b_i) + SW'(m) * SW'(p_j) + SW'(carry_in);
    assign sum_lo    = sum[WORD_WIDTH-1:0];
    assign carry_out = CW'(sum >> WORD_WIDTH);

endmodule

// File: rtl/fios_mm_seq.sv
// Self-sequenced word-serial FIOS Montgomery multiplier: RES = A*B*R^-1 mod P, streamed in/out LS word first.
module fios_mm_seq
    import fios_mm_pkg::*;
#(
    parameter int WORD_WIDTH = 17,
    parameter int s          = 8,
    parameter bit FINAL_SUB  = 1'b1
) (
    input  logic                  clock_i,
    input  logic                  reset_n_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [WORD_WIDTH-1:0] in_a_i,
    input  logic [WORD_WIDTH-1:0] in_b_i,
    input  logic [WORD_WIDTH-1:0] in_p_i,
    input  logic [WORD_WIDTH-1:0] p_prime_0_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [WORD_WIDTH-1:0] out_res_o,
    output logic                  out_last_o,
    output logic                  busy_o
);

    localparam int W  = WORD_WIDTH;
    localparam int CW = carry_width(W);
    localparam int KW = cnt_width(s);
    localparam int IW = $clog2(s);
    localparam logic [KW-1:0] S_LAST = KW'(s - 1);
    localparam logic [KW-1:0] S_FIN  = KW'(s);

    state_e         state_q, state_d;
    logic [KW-1:0]  k_q, k_d, i_q, i_d, j_q, j_d;
    logic [CW-1:0]  carry_q, carry_d;
    logic           borrow_q, borrow_d, sel_d_q, sel_d_d;
    logic [W-1:0]   a_q [s], a_d [s], b_q [s], b_d [s], p_q [s], p_d [s], d_q [s], d_d [s];
    logic [W-1:0]   t_q [s+1], t_d [s+1];
    logic [W-1:0]   pp_q, pp_d, m_q, m_d;

    logic [IW-1:0]  kk, ii, jj;
    logic [W-1:0]   m_seed, m_new, m_cur, step_lo;
    logic [CW-1:0]  step_carry;
    logic [CW:0]    fin_x;
    logic [W:0]     diff;

    assign kk = IW'(k_q);
    assign ii = IW'(i_q);
    assign jj = (j_q < S_FIN) ? IW'(j_q) : '0;

    // m is derived at j==0 from the partial sum's low word and reused for the rest of the row.
    assign m_seed = t_q[0] + a_q[0] * b_q[ii];
    assign m_new  = m_seed * pp_q;
    assign m_cur  = (j_q == '0) ? m_new : m_q;
    assign fin_x  = (CW+1)'(t_q[s]) + (CW+1)'(carry_q);
    assign diff   = {1'b0, t_q[k_q]} - {1'b0, p_q[kk]} - (W+1)'(borrow_q);

    fios_mm_step #(
        .WORD_WIDTH(W),
        .CW        (CW)
    ) u_step (
        .t_j      (t_q[j_q]),
        .a_j      (a_q[jj]),
        .b_i      (b_q[ii]),
        .m        (m_cur),
        .p_j      (p_q[jj]),
        .carry_in (carry_q),
        .sum_lo   (step_lo),
        .carry_out(step_carry)
    );

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        i_d      = i_q;
        j_d      = j_q;
        carry_d  = carry_q;
        borrow_d = borrow_q;
        sel_d_d  = sel_d_q;
        a_d      = a_q;
        b_d      = b_q;
        p_d      = p_q;
        d_d      = d_q;
        t_d      = t_q;
        pp_d     = pp_q;
        m_d      = m_q;
        unique case (state_q)
            ST_LOAD: begin
                if (in_valid_i) begin
                    a_d[kk] = in_a_i;
                    b_d[kk] = in_b_i;
                    p_d[kk] = in_p_i;
                    if (k_q == '0) begin
                        pp_d = p_prime_0_i;
                        for (int n = 0; n <= s; n++) t_d[n] = '0;
                    end
                    if (k_q == S_LAST) begin
                        state_d = ST_COMPUTE;
                        k_d     = '0;
                        i_d     = '0;
                        j_d     = '0;
                        carry_d = '0;
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end
            end
            ST_COMPUTE: begin
                if (j_q == S_FIN) begin
                    // Row finalise: fold the carry into the top two words of t.
                    t_d[s-1] = fin_x[W-1:0];
                    t_d[s]   = W'(fin_x >> W);
                    carry_d  = '0;
                    j_d      = '0;
                    if (i_q == S_LAST) begin
                        state_d  = FINAL_SUB ? ST_SUB : ST_OUT;
                        i_d      = '0;
                        k_d      = '0;
                        borrow_d = 1'b0;
                    end else begin
                        i_d = i_q + 1'b1;
                    end
                end else begin
                    if (j_q == '0) m_d = m_new;
                    else           t_d[j_q - 1'b1] = step_lo;
                    carry_d = step_carry;
                    j_d     = j_q + 1'b1;
                end
            end
            ST_SUB: begin
                d_d[kk]  = diff[W-1:0];
                borrow_d = diff[W];
                if (k_q == S_LAST) begin
                    sel_d_d = (|t_q[s]) | ~diff[W];
                    state_d = ST_OUT;
                    k_d     = '0;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            ST_OUT: begin
                if (out_ready_i) begin
                    if (k_q == S_LAST) begin
                        state_d = ST_LOAD;
                        k_d     = '0;
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    always_comb begin
        in_ready_o  = (state_q == ST_LOAD);
        out_valid_o = (state_q == ST_OUT);
        out_last_o  = out_valid_o && (k_q == S_LAST);
        out_res_o   = '0;
        if (out_valid_o) out_res_o = (FINAL_SUB && sel_d_q) ? d_q[kk] : t_q[k_q];
        busy_o      = !((state_q == ST_LOAD) && (k_q == '0));
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q  <= ST_LOAD;
            k_q      <= '0;
            i_q      <= '0;
            j_q      <= '0;
            carry_q  <= '0;
            borrow_q <= 1'b0;
            sel_d_q  <= 1'b0;
            for (int n = 0; n <= s; n++) t_q[n] <= '0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            i_q      <= i_d;
            j_q      <= j_d;
            carry_q  <= carry_d;
            borrow_q <= borrow_d;
            sel_d_q  <= sel_d_d;
            t_q      <= t_d;
        end
    end

    always_ff @(posedge clock_i) begin
        a_q  <= a_d;
        b_q  <= b_d;
        p_q  <= p_d;
        d_q  <= d_d;
        pp_q <= pp_d;
        m_q  <= m_d;
    end

endmodule

// File: doc/fios_mm_seq.md
Name: fios_mm_seq

Overview:
- Self-controlled, word-serial FIOS Montgomery multiplier that computes RES = A*B*R^-1 mod P, where R = 2^(WORD_WIDTH*s).
- Unlike the DSP-chain multiplier, it owns its control FSM and uses one time-multiplexed processing step.
- It applies the final conditional subtraction, so the result is fully reduced.
- Valid/ready streaming on both sides. It sits between the modexp sequencer and operand RAMs.

Parameters:
- WORD_WIDTH, 17, bits per word.
- s, 8, words per operand (s >= 2).
- FINAL_SUB, 1, 1: result reduced to [0,P); 0: skip the SUB state and output t (< 2P, t[s] dropped).

Ports:
- clock_i  in  1  clock.
- reset_n_i  in  1  asynchronous active-low reset.
- in_valid_i  in  1  input word valid.
- in_ready_o  out  1  high only in LOAD.
- in_a_i  in  WORD_WIDTH  A word, LS word first.
- in_b_i  in  WORD_WIDTH  B word, LS word first.
- in_p_i  in  WORD_WIDTH  modulus word, LS word first.
- p_prime_0_i  in  WORD_WIDTH  -P^-1 mod 2^WORD_WIDTH; sampled with word 0.
- out_valid_o  out  1  result word valid.
- out_ready_i  in  1  consumer accepts.
- out_res_o  out  WORD_WIDTH  result word, LS first.
- out_last_o  out  1  marks word s-1.
- busy_o  out  1  high in any state except LOAD with cnt==0.

Behaviour:
- Reset (asynchronous assert, synchronous release): state=LOAD, counters=0, t=0, in_ready_o=1, out_valid_o=0, out_last_o=0, out_res_o=0, busy_o=0.
- Reset mid-operation aborts the operation with no output; outputs go to reset values on the same edge.
- LOAD:
  - On each in_valid_i & in_ready_o, store word k of a, b, p; k increments.
  - At k==0, also capture p_prime_0_i and clear t[0..s].
  - After word s-1, go to COMPUTE with i=j=0 and carry=0.
- COMPUTE: one cycle per inner step.
  - j==0: m = ((t[0] + a[0]*b[i]) mod 2^W) * p' mod 2^W. m is combinational and registered for j>0.
  - Each inner step: sum = t[j] + a[j]*b[i] + m*p[j] + carry.
  - sum width is 2W+2; carry = sum>>W (W+2 bits).
  - For j>0: t[j-1] = sum[W-1:0]. For j==0 the low word is zero by construction and is discarded.
  - Finalise cycle (j==s): x = t[s] + carry; t[s-1] = x[W-1:0]; t[s] = x>>W (at most 1 bit given inputs < P).
  - i increments and j resets. After i==s-1 finalise, go to SUB (FINAL_SUB=1) or OUT.
  - Duration is exactly s*(s+1) cycles.
- SUB: s cycles, word-serial d[j] = t[j] - p[j] - borrow. Then sel_d = t[s] | ~borrow_final. Go to OUT.
- OUT:
  - out_res_o = sel_d ? d[k] : t[k]; out_valid_o=1; out_last_o=(k==s-1).
  - k advances on out_ready_i. Data is held stable while out_ready_i=0.
  - After the last word is accepted, go to LOAD. in_ready_o rises the next cycle; no overlap of load and output.
- Latency from the last input handshake to the first out_valid_o: s*(s+1)+s cycles (FINAL_SUB=1), s*(s+1) (FINAL_SUB=0).
- in_valid_i is ignored outside LOAD.
- Preconditions (not checked): P odd, A<P, B<P.

Decomposition:
- Package fios_mm_pkg holds:
  - state enum (LOAD, COMPUTE, SUB, OUT);
  - function clog2-based counter width;
  - constant CARRY_W = WORD_WIDTH+2.
- One sub-module, fios_mm_step: the combinational inner step.
  - Inputs: t_j, a_j, b_i, m, p_j, carry_in.
  - Outputs: sum low word, carry_out.

Test Plan (WORD_WIDTH=4, s=2, P=0xB5, p'=0x3 unless stated):
- A=0x01, B=0x4B (R mod P), back-to-back input, out_ready_i=1 -> out words 0x1, 0x0; out_last_o on word 1. First out_valid_o exactly 8 cycles after the last input handshake.
- A=B=0xB4 (P-1) -> result 0x46 (R^-1 mod P), words 0x6, 0x4.
- A=0x00, B=0x7F -> result 0x00. Same operands with FINAL_SUB=0 -> also 0x00.
- out_ready_i low for 5 cycles on word 0 -> out_res_o/out_last_o stable; in_ready_o stays 0 until the last word is accepted, then 1 the next cycle.
- reset_n_i pulsed low at compute cycle 3 -> outputs return to reset values immediately; next operation (A=1, B=0x4B) still yields 0x01.
- 10k random odd P, A,B<P, WORD_WIDTH=17, s=8, random valid/ready gaps -> matches golden A*B*R^-1 mod P; no output ever >= P.
